// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, frame width and baud divider math.
// Pure declarations; no latency. No backpressure.
// Used by uart_rx_os now and by the planned uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } uart_state_t;

    localparam int DATA_BITS = 8;

    // clk cycles per sample tick, rounded to nearest and never below 1
    function automatic int div_calc(input int clk_hz, input int baud, input int os);
        longint den;
        longint d;
        den = longint'(baud) * longint'(os);
        d   = (longint'(clk_hz) + den / 2) / den;
        return (d < 1) ? 1 : int'(d);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: one-clk tick every DIV clk cycles; clr re-zeroes the phase.
// Latency: tick asserts DIV-1 cycles after clr (every cycle when DIV=1).
// No backpressure; free-running.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with 3-sample majority vote and start-glitch rejection.
// Latency: rx_ready one clk after the stop-bit majority point (~9.5 bit times + 3 clk from the falling edge).
// No backpressure: rx_ready/frame_err are single-clk strobes; a consumer must take rx_data on the strobe.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV = div_calc(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);

    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_S0   = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] OS_S1   = OSW'(OVERSAMPLE / 2);
    localparam logic [OSW-1:0] OS_MAJ  = OSW'(OVERSAMPLE / 2 + 1);
    localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

    uart_state_t state, state_n;

    logic                 rx_m, rx_s, rx_d;
    logic [OSW-1:0]       os_cnt, os_n;
    logic [2:0]           bit_idx, bit_n;
    logic                 s0, s0_n, s1, s1_n;
    logic [DATA_BITS-1:0] shreg, sh_n;
    logic [7:0]           data_n;
    logic                 rdy_n, err_n;
    logic                 tick, tick_clr;
    logic                 maj, at_mid, at_last, fall;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Synchronizer resets to the idle level so reset release never looks like a start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall    = rx_d & ~rx_s;
    assign at_mid  = tick && (os_cnt == OS_MAJ);
    assign at_last = tick && (os_cnt == OS_LAST);
    // Third sample is the live rx_s at the evaluation point
    assign maj     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WAIT_IDLE;
            os_cnt    <= '0;
            bit_idx   <= '0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_ready  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            os_cnt    <= os_n;
            bit_idx   <= bit_n;
            s0        <= s0_n;
            s1        <= s1_n;
            shreg     <= sh_n;
            rx_data   <= data_n;
            rx_ready  <= rdy_n;
            frame_err <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        os_n     = os_cnt;
        bit_n    = bit_idx;
        s0_n     = s0;
        s1_n     = s1;
        sh_n     = shreg;
        data_n   = rx_data;
        rdy_n    = 1'b0;
        err_n    = 1'b0;
        tick_clr = 1'b0;

        if (tick && os_cnt == OS_S0) s0_n = rx_s;
        if (tick && os_cnt == OS_S1) s1_n = rx_s;

        case (state)
            WAIT_IDLE: begin
                // os_cnt doubles as the consecutive-high tick counter here
                if (!rx_s) begin
                    os_n = '0;
                end else if (tick) begin
                    if (os_cnt == OS_LAST) begin
                        os_n    = '0;
                        state_n = IDLE;
                    end else begin
                        os_n = os_cnt + OSW'(1);
                    end
                end
            end
            IDLE: begin
                os_n = '0;
                if (fall) begin
                    state_n  = START;
                    tick_clr = 1'b1;
                end
            end
            START: begin
                if (tick) os_n = at_last ? '0 : os_cnt + OSW'(1);
                if (at_mid && maj) begin
                    state_n = IDLE;
                    os_n    = '0;
                end else if (at_last) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (tick) os_n = at_last ? '0 : os_cnt + OSW'(1);
                if (at_mid) sh_n = {maj, shreg[DATA_BITS-1:1]};
                if (at_last) begin
                    if (bit_idx == BIT_LAST) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) os_n = os_cnt + OSW'(1);
                // Decide at the stop-bit midpoint so a back-to-back start edge is caught in IDLE
                if (at_mid) begin
                    os_n = '0;
                    if (maj) begin
                        data_n  = shreg;
                        rdy_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end
            end
            default: begin
                state_n = WAIT_IDLE;
                os_n    = '0;
            end
        endcase
    end

    assign busy = (state == START) || (state == DATA) || (state == STOP);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at 16 clk per bit (DIV=1).
// Strobes are captured by a negedge monitor and compared against hand-computed bytes.
module tb_uart_rx_os;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_cnt  = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int busy_cnt = 0;
    int rdy_cyc  = 0;
    int fall_cyc = 0;
    int r0, e0, b0, lat;
    logic [7:0] got_q[$];

    uart_rx_os #(
        .CLK_HZ     (1600000),
        .BAUD       (100000),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_ready) begin
            rdy_cnt = rdy_cnt + 1;
            rdy_cyc = cyc;
            got_q.push_back(rx_data);
        end
        if (frame_err) err_cnt = err_cnt + 1;
        if (rx_ready && frame_err) both_cnt = both_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pop_byte();
        if (got_q.size() == 0) return 8'hxx;
        return got_q.pop_front();
    endfunction

    // Drives one 16-clk bit; optionally inverts the middle majority sample for one clk
    task automatic send_bit(input logic b, input bit glitch);
        rx = b;
        if (glitch) begin
            repeat (9) @(negedge clk);
            rx = ~b;
            @(negedge clk);
            rx = b;
            repeat (6) @(negedge clk);
        end else begin
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int glitch_bit);
        fall_cyc = cyc;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch_bit == i);
        send_bit(stop_b, 1'b0);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rx  = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_rx_data", rx_data, 8'h00);
        check_eq("reset_rx_ready", rx_ready, 1'b0);
        check_eq("reset_frame_err", frame_err, 1'b0);
        check_eq("reset_busy", busy, 1'b0);
        rst = 1'b1;
        idle(20);

        // Single good frame
        send_frame(8'hA5, 1'b1, -1);
        idle(10);
        lat = rdy_cyc - fall_cyc;
        check_eq("t1_ready_count", rdy_cnt, 1);
        check_eq("t1_frame_err_count", err_cnt, 0);
        check_eq("t1_byte", pop_byte(), 8'hA5);
        check_eq("t1_rx_data", rx_data, 8'hA5);
        check_eq("t1_busy_after", busy, 1'b0);
        check_eq("t1_latency_window", (lat >= 150 && lat <= 160), 1'b1);

        // Framing error, then recovery after the line idles
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, -1);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        idle(20);
        check_eq("t3_frame_err_delta", err_cnt - e0, 1);
        check_eq("t3_ready_delta", rdy_cnt - r0, 0);
        check_eq("t3_rx_data_held", rx_data, 8'hA5);
        send_frame(8'h12, 1'b1, -1);
        idle(10);
        check_eq("t3_recover_byte", pop_byte(), 8'h12);
        check_eq("t3_recover_ready_delta", rdy_cnt - r0, 1);

        // Start-bit glitch of 4 clk
        r0 = rdy_cnt; e0 = err_cnt; b0 = busy_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(30);
        check_eq("t2_busy_pulsed", (busy_cnt - b0) > 0, 1'b1);
        check_eq("t2_ready_delta", rdy_cnt - r0, 0);
        check_eq("t2_frame_err_delta", err_cnt - e0, 0);
        check_eq("t2_busy_after", busy, 1'b0);
        send_frame(8'h3C, 1'b1, -1);
        idle(10);
        check_eq("t2_next_byte", pop_byte(), 8'h3C);

        // Back-to-back frames with single stop bits
        r0 = rdy_cnt;
        send_frame(8'h34, 1'b1, -1);
        send_frame(8'h12, 1'b1, -1);
        send_frame(8'h08, 1'b1, -1);
        send_frame(8'h00, 1'b1, -1);
        idle(10);
        check_eq("t4_ready_delta", rdy_cnt - r0, 4);
        check_eq("t4_byte0", pop_byte(), 8'h34);
        check_eq("t4_byte1", pop_byte(), 8'h12);
        check_eq("t4_byte2", pop_byte(), 8'h08);
        check_eq("t4_byte3", pop_byte(), 8'h00);

        // Reset in data bit 3 of 0x77, released during the low bit 7
        r0 = rdy_cnt; e0 = err_cnt;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("t5_rst_rx_data", rx_data, 8'h00);
        check_eq("t5_rst_rx_ready", rx_ready, 1'b0);
        check_eq("t5_rst_frame_err", frame_err, 1'b0);
        check_eq("t5_rst_busy", busy, 1'b0);
        repeat (8) @(negedge clk);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        send_bit(1'b1, 1'b0);
        idle(30);
        check_eq("t5_no_ready", rdy_cnt - r0, 0);
        check_eq("t5_no_frame_err", err_cnt - e0, 0);
        check_eq("t5_rx_data_cleared", rx_data, 8'h00);
        send_frame(8'h5A, 1'b1, -1);
        idle(10);
        check_eq("t5_next_byte", pop_byte(), 8'h5A);

        // One corrupted mid-bit sample in bit 4 of 0xFF
        send_frame(8'hFF, 1'b1, 4);
        idle(10);
        check_eq("t6_majority_byte", pop_byte(), 8'hFF);
        check_eq("t6_rx_data", rx_data, 8'hFF);

        check_eq("strobes_never_overlap", both_cnt, 0);
        check_eq("total_frame_errs", err_cnt, 1);
        check_eq("no_extra_bytes", got_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
